// File: rtl/ultrasonic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ultrasonic_pkg
//  Purpose  : Shared types and constants for the ultrasonic scan scheduler.
//             Holds the scheduler FSM state encoding, the measurement word
//             width and the sound-speed conversion constant.
//  Revision : 1.0  initial release
// ============================================================================
package ultrasonic_pkg;

    // Width of measurement words (echo width in us, state timers).
    localparam int MEAS_W = 16;

    // Round-trip echo time per centimetre of range, in microseconds.
    localparam int US_PER_CM = 58;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        GUARD     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/us_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : us_tick_gen
//  Purpose  : Microsecond prescaler. Counts 0..CYCLES_PER_US-1 and raises
//             tick for one cycle on the terminal count. clear forces the
//             count back to 0 so every FSM state starts on a fresh
//             microsecond boundary.
//  Ports    : clk   in  system clock
//             rst   in  asynchronous active-high reset
//             clear in  restart the count at 0 on the next edge
//             tick  out one-cycle pulse on terminal count
//  Revision : 1.0  initial release
// ============================================================================
module us_tick_gen
    import ultrasonic_pkg::*;
#(
    parameter int CYCLES_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(CYCLES_PER_US - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == C_TERM)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Left ungated by clear: the FSM uses this very tick to decide when to
    // change state, and that state change is what drives clear.
    assign tick = (r_cnt == C_TERM);

endmodule
`default_nettype wire

// File: rtl/ultrasonic_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ultrasonic_scan_scheduler
//  Purpose  : Round-robin scheduler for NUM_SENSORS HC-SR04 style rangers.
//             Fires one sensor at a time, times its echo in microseconds,
//             reports each measurement as a one-cycle beat and keeps a
//             per-sensor crash flag (object inside the NEAR..FAR window).
//  Ports    : clk          in  system clock
//             rst          in  asynchronous active-high reset
//             enable       in  scanning permitted
//             trigger      out one-hot trigger pulses to the rangers
//             echo         in  raw asynchronous echo lines
//             meas_valid   out one-cycle pulse, measurement completed
//             meas_id      out sensor index of the measurement
//             meas_us      out echo width in us
//             meas_timeout out measurement ended by timeout
//             is_crash     out registered per-sensor crash flags
//             busy         out FSM not in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module ultrasonic_scan_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int NUM_SENSORS   = 4,
    parameter int CYCLES_PER_US = 100,
    parameter int TRIG_US       = 10,
    parameter int WAIT_RISE_US  = 500,
    parameter int ECHO_MAX_US   = 30000,
    parameter int GUARD_US      = 60000,
    parameter int NEAR_US       = 348,
    parameter int FAR_US        = 870,
    localparam int IDX_W        = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic [NUM_SENSORS-1:0] trigger,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic                   meas_valid,
    output logic [IDX_W-1:0]       meas_id,
    output logic [MEAS_W-1:0]      meas_us,
    output logic                   meas_timeout,
    output logic [NUM_SENSORS-1:0] is_crash,
    output logic                   busy
);

    localparam logic [MEAS_W-1:0] C_TRIG_LAST  = MEAS_W'(TRIG_US - 1);
    localparam logic [MEAS_W-1:0] C_WAIT_LAST  = MEAS_W'(WAIT_RISE_US - 1);
    localparam logic [MEAS_W-1:0] C_GUARD_LAST = MEAS_W'(GUARD_US - 1);
    localparam logic [MEAS_W-1:0] C_ECHO_MAX   = MEAS_W'(ECHO_MAX_US);
    localparam logic [MEAS_W-1:0] C_NEAR       = MEAS_W'(NEAR_US);
    localparam logic [MEAS_W-1:0] C_FAR        = MEAS_W'(FAR_US);
    localparam logic [IDX_W-1:0]  C_LAST_IDX   = IDX_W'(NUM_SENSORS - 1);

    state_t                   r_state, w_state_next;
    logic [IDX_W-1:0]         r_idx, w_idx_next;
    logic [MEAS_W-1:0]        r_cnt;
    logic [NUM_SENSORS-1:0]   r_sync1, r_sync2;
    logic                     r_echo_cur, r_echo_prev;
    logic [NUM_SENSORS-1:0]   r_trigger;
    logic                     r_meas_valid;
    logic [IDX_W-1:0]         r_meas_id;
    logic [MEAS_W-1:0]        r_meas_us;
    logic                     r_meas_timeout;
    logic [NUM_SENSORS-1:0]   r_is_crash;

    logic                     w_tick;
    logic                     w_clear;
    logic                     w_fall;
    logic                     w_cnt_step;
    logic [MEAS_W-1:0]        w_cnt_plus;
    logic                     w_complete;
    logic                     w_timeout;
    logic [MEAS_W-1:0]        w_result;
    logic                     w_crash;

    us_tick_gen #(
        .CYCLES_PER_US (CYCLES_PER_US)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Every state entry restarts both the prescaler and the state timer.
    assign w_clear    = (w_state_next != r_state);
    assign w_cnt_plus = r_cnt + MEAS_W'(1);
    // r_echo_cur is the registered edge-detect stage behind the 2-FF
    // synchronizer, so a pin fall reaches meas_valid in exactly 4 cycles.
    assign w_fall     = r_echo_prev & ~r_echo_cur;
    assign w_crash    = !w_timeout && (w_result >= C_NEAR) && (w_result <= C_FAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_step   = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_result     = '0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = TRIG;
                end
            end
            TRIG: begin
                w_cnt_step = w_tick;
                if (w_tick && (r_cnt == C_TRIG_LAST)) begin
                    w_state_next = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                w_cnt_step = w_tick;
                // A line already high on entry is taken as the rise.
                if (r_echo_cur) begin
                    w_state_next = MEASURE;
                end else if (w_tick && (r_cnt == C_WAIT_LAST)) begin
                    w_complete   = 1'b1;
                    w_timeout    = 1'b1;
                    w_state_next = GUARD;
                end
            end
            MEASURE: begin
                // Counting on the delayed echo lines the count window up
                // with MEASURE entry, so an echo of exactly N us reads N
                // and the last tick can land in the fall-detect cycle.
                w_cnt_step = w_tick & r_echo_prev;
                if (w_cnt_step && (w_cnt_plus == C_ECHO_MAX)) begin
                    w_complete   = 1'b1;
                    w_timeout    = 1'b1;
                    w_result     = C_ECHO_MAX;
                    w_state_next = GUARD;
                end else if (w_fall) begin
                    w_complete   = 1'b1;
                    w_result     = w_cnt_step ? w_cnt_plus : r_cnt;
                    w_state_next = GUARD;
                end
            end
            GUARD: begin
                w_cnt_step = w_tick;
                if (w_tick && (r_cnt == C_GUARD_LAST)) begin
                    w_idx_next   = (r_idx == C_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                    w_state_next = enable ? TRIG : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_echo_cur     <= 1'b0;
            r_echo_prev    <= 1'b0;
            r_cnt          <= '0;
            r_trigger      <= '0;
            r_meas_valid   <= 1'b0;
            r_meas_id      <= '0;
            r_meas_us      <= '0;
            r_meas_timeout <= 1'b0;
            r_is_crash     <= '0;
        end else begin
            r_sync1     <= echo;
            r_sync2     <= r_sync1;
            r_echo_cur  <= r_sync2[r_idx];
            r_echo_prev <= r_echo_cur;

            if (w_clear) begin
                r_cnt <= '0;
            end else if (w_cnt_step) begin
                r_cnt <= w_cnt_plus;
            end

            // Registered from the next state so the pulse is glitch-free
            // and spans exactly the cycles spent in TRIG.
            r_trigger <= (w_state_next == TRIG) ? (NUM_SENSORS'(1) << w_idx_next) : '0;

            r_meas_valid <= w_complete;
            if (w_complete) begin
                r_meas_id          <= r_idx;
                r_meas_us          <= w_result;
                r_meas_timeout     <= w_timeout;
                r_is_crash[r_idx]  <= w_crash;
            end
        end
    end

    assign trigger      = r_trigger;
    assign meas_valid   = r_meas_valid;
    assign meas_id      = r_meas_id;
    assign meas_us      = r_meas_us;
    assign meas_timeout = r_meas_timeout;
    assign is_crash     = r_is_crash;
    assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ultrasonic_scan_scheduler
//  Purpose  : Directed self-checking bench for ultrasonic_scan_scheduler with
//             small timing parameters (10 clk/us, 10 us trigger, 50 us rise
//             window, 2000 us echo ceiling, 100 us guard, 4 sensors).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ultrasonic_scan_scheduler;

    localparam int N   = 4;
    localparam int CPU = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [N-1:0] trigger;
    logic [N-1:0] echo;
    logic         meas_valid;
    logic [1:0]   meas_id;
    logic [15:0]  meas_us;
    logic         meas_timeout;
    logic [N-1:0] is_crash;
    logic         busy;

    int n_checks       = 0;
    int n_pass         = 0;
    int cyc            = 0;
    int viol           = 0;
    int last_valid_cyc = 0;

    ultrasonic_scan_scheduler #(
        .NUM_SENSORS   (N),
        .CYCLES_PER_US (CPU),
        .TRIG_US       (10),
        .WAIT_RISE_US  (50),
        .ECHO_MAX_US   (2000),
        .GUARD_US      (100),
        .NEAR_US       (348),
        .FAR_US        (870)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .trigger      (trigger),
        .echo         (echo),
        .meas_valid   (meas_valid),
        .meas_id      (meas_id),
        .meas_us      (meas_us),
        .meas_timeout (meas_timeout),
        .is_crash     (is_crash),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Trigger must stay one-hot and only appear while the scheduler is busy.
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(trigger) > 1) viol = viol + 1;
            if ((trigger != '0) && !busy) viol = viol + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic wait_trigger(input int idx, input bit chk_guard);
        int w;
        w = 0;
        while ((trigger == '0) && (w < 3000)) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("s%0d trig_sel", idx), 32'(trigger), 32'(1) << idx);
        if (chk_guard) check($sformatf("s%0d guard_gap", idx), cyc - last_valid_cyc, 1000);
        w = 0;
        while ((trigger != '0) && (w < 200)) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("s%0d trig_len", idx), w, 10 * CPU);
    endtask

    // mode 0: echo pulse of width_us, 1: no echo, 2: echo stuck high
    task automatic run_sensor(input int idx, input int mode, input int width_us,
                              input bit chk_guard, input bit drop_en,
                              input int exp_us, input int exp_to, input int exp_lat,
                              input logic [3:0] exp_crash);
        int lat;
        bit seen;
        if (mode == 2) echo[idx] = 1'b1;
        wait_trigger(idx, chk_guard);
        if (mode == 0) begin
            @(negedge clk);
            echo[idx] = 1'b1;
            for (int i = 0; i < width_us * CPU; i++) begin
                if (drop_en && (i == 100)) enable = 1'b0;
                @(negedge clk);
            end
            echo[idx] = 1'b0;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && (lat < 25000)) begin
            @(negedge clk);
            lat++;
            seen = meas_valid;
        end
        check($sformatf("s%0d meas_seen", idx), 32'(seen), 1);
        check($sformatf("s%0d meas_id", idx), 32'(meas_id), idx);
        check($sformatf("s%0d meas_us", idx), 32'(meas_us), exp_us);
        check($sformatf("s%0d meas_timeout", idx), 32'(meas_timeout), exp_to);
        check($sformatf("s%0d latency", idx), lat, exp_lat);
        check($sformatf("s%0d is_crash", idx), 32'(is_crash), 32'(exp_crash));
        last_valid_cyc = cyc;
        if (mode == 2) echo[idx] = 1'b0;
        @(negedge clk);
        check($sformatf("s%0d valid_single", idx), 32'(meas_valid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " trigger"}, 32'(trigger), 0);
        check({tag, " meas_valid"}, 32'(meas_valid), 0);
        check({tag, " meas_id"}, 32'(meas_id), 0);
        check({tag, " meas_us"}, 32'(meas_us), 0);
        check({tag, " meas_timeout"}, 32'(meas_timeout), 0);
        check({tag, " is_crash"}, 32'(is_crash), 0);
        check({tag, " busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        echo   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_enable busy", 32'(busy), 0);
        enable = 1'b1;

        // Window boundaries and the basic 500 us measurement.
        run_sensor(0, 0, 500, 1'b0, 1'b0, 500, 0, 4, 4'b0001);
        run_sensor(1, 0, 348, 1'b1, 1'b0, 348, 0, 4, 4'b0011);
        run_sensor(2, 0, 870, 1'b1, 1'b0, 870, 0, 4, 4'b0111);
        run_sensor(3, 0, 871, 1'b1, 1'b0, 871, 0, 4, 4'b0111);
        // No rise within 50 us: timeout, and sensor 0's crash bit clears.
        run_sensor(0, 1, 0,   1'b1, 1'b0, 0,    1, 500,   4'b0110);
        // Stuck-high line saturates at 2000 us.
        run_sensor(1, 2, 0,   1'b1, 1'b0, 2000, 1, 20001, 4'b0100);

        // Asynchronous reset in the middle of sensor 2's MEASURE.
        wait_trigger(2, 1'b1);
        @(negedge clk);
        echo[2] = 1'b1;
        repeat (300) @(negedge clk);
        check("pre_reset busy", 32'(busy), 1);
        #2;
        rst  = 1'b1;
        echo = '0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;

        // Full round-robin scan; enable dropped during the wrap-around sensor.
        run_sensor(0, 0, 100,  1'b0, 1'b0, 100,  0, 4, 4'b0000);
        run_sensor(1, 0, 400,  1'b1, 1'b0, 400,  0, 4, 4'b0010);
        run_sensor(2, 0, 900,  1'b1, 1'b0, 900,  0, 4, 4'b0010);
        run_sensor(3, 0, 1500, 1'b1, 1'b0, 1500, 0, 4, 4'b0010);
        run_sensor(0, 0, 100,  1'b1, 1'b1, 100,  0, 4, 4'b0010);

        repeat (1010) @(negedge clk);
        check("disabled busy", 32'(busy), 0);
        check("disabled trigger", 32'(trigger), 0);
        enable = 1'b1;
        // Resumes on the next sensor; 347 us sits just below the window.
        run_sensor(1, 0, 347, 1'b0, 1'b0, 347, 0, 4, 4'b0000);

        check("trigger_onehot_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ultrasonic_scan_scheduler.md
Name: ultrasonic_scan_scheduler

Overview:
Time-multiplexes N HC-SR04-style ultrasonic rangers so that only one sensor fires at a time, which avoids acoustic crosstalk. For each sensor it issues the trigger pulse, measures echo width in microseconds, and flags a crash when the object is inside the near/far window. It feeds per-sensor is_crash bits and measurement beats to the motor controller.

Parameters:
NUM_SENSORS, 4, number of rangers scheduled round-robin (1..8)
CYCLES_PER_US, 100, clk cycles per microsecond (prescaler terminal count)
TRIG_US, 10, trigger high time in us
WAIT_RISE_US, 500, max us from trigger fall to echo rise before "no sensor"
ECHO_MAX_US, 30000, echo-width timeout/saturation in us
GUARD_US, 60000, quiet time after each measurement before the next trigger
NEAR_US, 348, crash window lower bound (~6 cm, 58 us/cm)
FAR_US, 870, crash window upper bound (~15 cm)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  scanning permitted
trigger  out  NUM_SENSORS  one-hot trigger pulses to rangers
echo  in  NUM_SENSORS  raw echo lines (asynchronous)
meas_valid  out  1  one-cycle pulse: a measurement completed
meas_id  out  $clog2(NUM_SENSORS) (min 1)  sensor index for meas_valid
meas_us  out  16  echo width in us, valid with meas_valid
meas_timeout  out  1  measurement ended by timeout, valid with meas_valid
is_crash  out  NUM_SENSORS  registered per-sensor crash flags
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE, idx=0, trigger=0, meas_valid=0, meas_id=0, meas_us=0, meas_timeout=0, is_crash=0, busy=0, synchronizers cleared. Reset mid-pulse drops trigger immediately.
- echo passes through 2-FF synchronizers. Only echo[idx] is observed; the others are ignored.
- us_tick: prescaler counts 0..CYCLES_PER_US-1. It restarts at 0 on every state entry, and a tick fires on the terminal count. All state timers count us_ticks.
- FSM:
  - IDLE: if enable, go to TRIG.
  - TRIG: trigger[idx]=1 for exactly TRIG_US ticks (TRIG_US*CYCLES_PER_US cycles), then go to WAIT_RISE.
  - WAIT_RISE: on synced echo=1, go to MEASURE with the counter at 0. If WAIT_RISE_US ticks elapse first, complete with timeout=1, us=0.
  - MEASURE: increment the us counter on each tick while echo is high. On synced falling edge, complete with timeout=0 and us=counter. If the counter reaches ECHO_MAX_US, complete with timeout=1 and us=ECHO_MAX_US; the counter saturates and never wraps.
  - complete: a single cycle asserts meas_valid with id/us/timeout. In the same edge, is_crash[idx] <= !timeout && NEAR_US<=us<=FAR_US (inclusive); other bits hold. Then go to GUARD.
  - GUARD: wait GUARD_US ticks, ignoring echo. Then idx <= (idx==NUM_SENSORS-1)?0:idx+1. Go to TRIG if enable, else IDLE.
- enable deasserted mid-scan: the current sensor finishes through GUARD, then the FSM returns to IDLE. idx advances and is kept, so scanning resumes with the next sensor.
- Echo high already at WAIT_RISE entry (stuck line) counts as a rise. Its measurement then times out or completes normally.
- Latency: echo pin fall → meas_valid after 2 sync cycles + 1 edge-detect cycle + 1 register = 4 clk cycles, with ±0 jitter on the us count.
- One trigger bit is high at most at any time. Trigger never asserts outside TRIG.

Decomposition:
- Package ultrasonic_pkg: FSM state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GUARD), US_PER_CM=58 constant, MEAS_W=16.
- Sub-module us_tick_gen: prescaler with a clear input and a one-cycle tick output. Everything else stays in one module.

Test Plan:
(Sim params: CYCLES_PER_US=10, TRIG_US=10, WAIT_RISE_US=50, ECHO_MAX_US=2000, GUARD_US=100, NUM_SENSORS=4)
- Reset, then enable=1 → trigger[0] high exactly 100 cycles, then low; no other trigger bit ever set.
- Sensor 0 echo high 500 us → meas_valid with id=0, us=500, timeout=0; is_crash[0]=1.
- Echo 348 us and 870 us → is_crash=1 for both; echo 347 us and 871 us → is_crash=0.
- No echo rise → meas_valid after 50 us with timeout=1, us=0, is_crash cleared. Echo stuck high → us=2000, timeout=1.
- Four sensors with echoes of 100/400/900/1500 us → ids 0,1,2,3,0 in order, GUARD of 1000 cycles between each; is_crash=4'b0010.
- rst asserted during MEASURE → all outputs 0 asynchronously. Deassert enable in MEASURE → that measurement still reported, then IDLE; re-enable → next trigger is on idx+1.
